// File: rtl/mlp_hls_dl_pkg.sv
// Shared types and helpers for the MLP HLS deadlock report controller.
// FSM state codes, pid width, one-hot and round-robin pick helpers.
package mlp_hls_dl_pkg;

  localparam int MAX_PROC = 64;
  localparam int MAX_PID_W = 6;

  typedef logic [MAX_PID_W-1:0] max_pid_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  function automatic int pid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_PROC-1:0] onehot(
    input max_pid_t id
  );
    logic [MAX_PROC-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Scan from ptr upward with wrap; the candidate nearest
  // to ptr is visited last so it wins.
  function automatic max_pid_t rr_first(
    input logic [MAX_PROC-1:0] vec,
    input max_pid_t            ptr,
    input int                  n
  );
    max_pid_t r;
    int       idx;
    r = '0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (vec[idx[MAX_PID_W-1:0]]) r = idx[MAX_PID_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mlp_hls_dl_rr_arbiter.sv
// Round-robin pick over N requesters with a registered pointer.
// Ports: req in, advance (commit grant) in, grant_valid/grant_id out.
import mlp_hls_dl_pkg::*;

module mlp_hls_dl_rr_arbiter #(
  parameter int N     = 4,
  parameter int PID_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic             grant_valid,
  output logic [PID_W-1:0] grant_id
);

  logic [PID_W-1:0] ptr_q;
  logic [PID_W-1:0] ptr_d;

  always_comb begin
    grant_valid = |req;
    grant_id = PID_W'(rr_first(
      MAX_PROC'(req), max_pid_t'(ptr_q), N));
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      if (grant_id == PID_W'(N - 1)) ptr_d = '0;
      else ptr_d = grant_id + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mlp_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer: debounce, elect origin, walk token ring,
// latch report. Ports: unit flags/ring in, broadcast/report out.
import mlp_hls_dl_pkg::*;

module mlp_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM = 4,
  parameter int DEBOUNCE = 8,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16,
  localparam int PID_W   = pid_width(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_ring_vec,
  input  logic                report_ack,
  input  logic                clear_req,
  output logic                dl_detect_global,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic [PROC_NUM-1:0] token_clear_vec,
  output logic                report_valid,
  output logic [PID_W-1:0]    report_origin,
  output logic [PROC_NUM-1:0] report_mask,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    deadlock_cnt
);

  localparam int DEB_W =
    (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int WALK_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]          state_q, state_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [WALK_W-1:0]   walk_q, walk_d;
  logic [PID_W-1:0]    origin_q, origin_d;
  logic [PROC_NUM-1:0] path_q, path_d;
  logic [PID_W-1:0]    rep_origin_q, rep_origin_d;
  logic [PROC_NUM-1:0] rep_mask_q, rep_mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [PROC_NUM-1:0] origin_oh;
  logic                tok_ret;
  logic                arb_adv;
  logic                arb_valid;
  logic [PID_W-1:0]    arb_id;

  mlp_hls_dl_rr_arbiter #(
    .N     (PROC_NUM),
    .PID_W (PID_W)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (dl_detect_vec),
    .advance     (arb_adv),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    walk_d       = walk_q;
    origin_d     = origin_q;
    path_d       = path_q;
    rep_origin_d = rep_origin_q;
    rep_mask_d   = rep_mask_q;
    cnt_d        = cnt_q;

    origin_oh = PROC_NUM'(onehot(max_pid_t'(origin_q)));
    tok_ret   = token_ring_vec[origin_q];

    dl_detect_global = 1'b0;
    origin_vec       = '0;
    token_clear_vec  = '0;
    report_valid     = 1'b0;
    timeout_err      = 1'b0;
    arb_adv          = 1'b0;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (clear_req || !(|dl_detect_vec)) begin
          deb_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE - 1)) begin
          deb_d   = '0;
          state_d = S_ARB;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      (state_q == S_ARB): begin
        if (!arb_valid) begin
          state_d = S_IDLE;
        end else begin
          origin_d = arb_id;
          arb_adv  = !clear_req;
          state_d  = S_LAUNCH;
        end
      end
      (state_q == S_LAUNCH): begin
        dl_detect_global = 1'b1;
        origin_vec       = origin_oh;
        path_d           = origin_oh;
        walk_d           = '0;
        state_d          = S_WALK;
      end
      (state_q == S_WALK): begin
        dl_detect_global = 1'b1;
        path_d = path_q | token_ring_vec;
        walk_d = walk_q + 1'b1;
        if (tok_ret) begin
          // Same-cycle clear keeps the origin unit's token intact.
          if (!clear_req) token_clear_vec = origin_oh;
          rep_origin_d = origin_q;
          rep_mask_d   = path_q | token_ring_vec;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = S_REPORT;
        end else if (walk_q == WALK_W'(TIMEOUT - 1)) begin
          timeout_err = !clear_req;
          state_d     = S_IDLE;
        end
      end
      (state_q == S_REPORT): begin
        dl_detect_global = 1'b1;
        report_valid     = 1'b1;
        if (report_ack) state_d = S_HOLD;
      end
      (state_q == S_HOLD): begin
        dl_detect_global = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clear_req && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      deb_d        = '0;
      walk_d       = '0;
      origin_d     = '0;
      path_d       = '0;
      rep_origin_d = '0;
      rep_mask_d   = '0;
      cnt_d        = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      deb_q        <= '0;
      walk_q       <= '0;
      origin_q     <= '0;
      path_q       <= '0;
      rep_origin_q <= '0;
      rep_mask_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      deb_q        <= deb_d;
      walk_q       <= walk_d;
      origin_q     <= origin_d;
      path_q       <= path_d;
      rep_origin_q <= rep_origin_d;
      rep_mask_q   <= rep_mask_d;
      cnt_q        <= cnt_d;
    end
  end

  assign report_origin = rep_origin_q;
  assign report_mask   = rep_mask_q;
  assign deadlock_cnt  = cnt_q;

endmodule

// File: tb/tb_mlp_hls_deadlock_report_ctrl.sv
// Directed + randomized bench for the deadlock report controller.
// Reference model tracks round-robin pointer, path mask and count.
module tb_mlp_hls_deadlock_report_ctrl;

  localparam int N   = 4;
  localparam int DEB = 8;
  localparam int TO  = 64;
  localparam int CW  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  dl_detect_vec = '0;
  logic [N-1:0]  token_ring_vec = '0;
  logic          report_ack = 1'b0;
  logic          clear_req = 1'b0;
  logic          dl_detect_global;
  logic [N-1:0]  origin_vec;
  logic [N-1:0]  token_clear_vec;
  logic          report_valid;
  logic [1:0]    report_origin;
  logic [N-1:0]  report_mask;
  logic          timeout_err;
  logic [CW-1:0] deadlock_cnt;

  mlp_hls_deadlock_report_ctrl #(
    .PROC_NUM (N),
    .DEBOUNCE (DEB),
    .TIMEOUT  (TO),
    .CNT_W    (CW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dl_detect_vec    (dl_detect_vec),
    .token_ring_vec   (token_ring_vec),
    .report_ack       (report_ack),
    .clear_req        (clear_req),
    .dl_detect_global (dl_detect_global),
    .origin_vec       (origin_vec),
    .token_clear_vec  (token_clear_vec),
    .report_valid     (report_valid),
    .report_origin    (report_origin),
    .report_mask      (report_mask),
    .timeout_err      (timeout_err),
    .deadlock_cnt     (deadlock_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int rr     = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: first asserted requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] v,
                                    input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int id);
    logic [N-1:0] r;
    r = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  // Hold vec until LAUNCH; check latency and elected origin.
  task automatic elect(input logic [N-1:0] v, output int org);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    @(negedge clock);
    dl_detect_vec = v;
    repeat (DEB + 6) begin
      @(negedge clock);
      n++;
      if (origin_vec != '0) begin
        seen = 1;
        break;
      end
    end
    chk("launch_latency", n, DEB + 1);
    org = model_pick(v, rr);
    rr = (org + 1) % N;
    chk("origin_vec", origin_vec, oh(org));
    chk("global_launch", dl_detect_global, 1);
    chk("no_tclr_launch", token_clear_vec, 0);
  endtask

  // Drive ring arrivals one per WALK cycle; returns expected mask.
  task automatic walk(input logic [N-1:0] ring[$],
                      input int org,
                      output logic [N-1:0] m);
    m = oh(org);
    foreach (ring[i]) begin
      @(negedge clock);
      token_ring_vec = ring[i];
      #1;
      m = m | ring[i];
      if (ring[i][org]) chk("tclr_ret", token_clear_vec, oh(org));
      else chk("tclr_idle", token_clear_vec, 0);
      chk("origin_walk", origin_vec, 0);
    end
  endtask

  task automatic report(input int org,
                        input logic [N-1:0] m,
                        input int ackdly);
    @(negedge clock);
    token_ring_vec = '0;
    if (exp_cnt < 2**CW - 1) exp_cnt++;
    chk("rep_valid", report_valid, 1);
    chk("rep_origin", report_origin, org);
    chk("rep_mask", report_mask, m);
    chk("rep_cnt", deadlock_cnt, exp_cnt);
    repeat (ackdly) begin
      @(negedge clock);
      chk("rep_valid_hold", report_valid, 1);
      chk("rep_mask_hold", report_mask, m);
    end
    report_ack = 1'b1;
    @(negedge clock);
    report_ack = 1'b0;
    chk("hold_valid", report_valid, 0);
    chk("hold_global", dl_detect_global, 1);
    chk("hold_origin", report_origin, org);
    dl_detect_vec = '0;
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    chk("clr_global", dl_detect_global, 0);
    chk("clr_mask", report_mask, 0);
    chk("clr_cnt", deadlock_cnt, exp_cnt);
  endtask

  initial begin : main
    int org;
    logic [N-1:0] m;
    logic [N-1:0] ring[$];
    logic [N-1:0] v;

    // Reset state
    #12;
    chk("rst_global", dl_detect_global, 0);
    chk("rst_valid", report_valid, 0);
    chk("rst_cnt", deadlock_cnt, 0);
    @(negedge clock);
    reset = 1'b1;

    // Short pulse below debounce threshold
    dl_detect_vec = 4'b0100;
    repeat (5) @(negedge clock);
    dl_detect_vec = '0;
    repeat (12) begin
      @(negedge clock);
      chk("deb_origin", origin_vec, 0);
      chk("deb_global", dl_detect_global, 0);
    end

    // Round robin on 1010, cleared between
    elect(4'b1010, org);
    ring = '{4'b0100, oh(org)};
    walk(ring, org, m);
    report(org, m, 0);
    elect(4'b1010, org);
    ring = '{4'b0001, oh(org)};
    walk(ring, org, m);
    report(org, m, 1);

    // Ring 2->3->0->2 with long ack wait
    elect(4'b0100, org);
    ring = '{4'b1000, 4'b0001, 4'b0100};
    walk(ring, org, m);
    report(org, m, 10);

    // Token never returns: timeout on WALK cycle TO
    elect(4'b0001, org);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clock);
      if (i == TO) dl_detect_vec = '0;
      #1;
      chk("to_pulse", timeout_err, (i == TO) ? 1 : 0);
    end
    @(negedge clock);
    chk("to_global", dl_detect_global, 0);
    chk("to_valid", report_valid, 0);
    chk("to_cnt", deadlock_cnt, exp_cnt);

    // Clear coincident with token return is discarded
    elect(4'b0011, org);
    @(negedge clock);
    token_ring_vec = oh(org);
    clear_req = 1'b1;
    #1;
    chk("clr_walk_tclr", token_clear_vec, 0);
    @(negedge clock);
    clear_req = 1'b0;
    token_ring_vec = '0;
    dl_detect_vec = '0;
    chk("clr_walk_valid", report_valid, 0);
    chk("clr_walk_global", dl_detect_global, 0);
    chk("clr_walk_cnt", deadlock_cnt, exp_cnt);

    // Randomized deadlocks
    for (int t = 0; t < 6; t++) begin
      v = N'($urandom_range(1, 2**N - 1));
      elect(v, org);
      ring = {};
      for (int j = 0; j < int'($urandom_range(0, 4)); j++)
        ring.push_back(N'($urandom) & ~oh(org));
      ring.push_back(N'($urandom) | oh(org));
      walk(ring, org, m);
      report(org, m, int'($urandom_range(0, 3)));
    end

    // Async reset during WALK
    elect(4'b0110, org);
    @(negedge clock);
    token_ring_vec = 4'b1000;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_global", dl_detect_global, 0);
    chk("arst_origin_vec", origin_vec, 0);
    chk("arst_tclr", token_clear_vec, 0);
    chk("arst_valid", report_valid, 0);
    chk("arst_rep_origin", report_origin, 0);
    chk("arst_mask", report_mask, 0);
    chk("arst_to", timeout_err, 0);
    chk("arst_cnt", deadlock_cnt, 0);
    token_ring_vec = '0;
    dl_detect_vec = '0;
    @(negedge clock);
    reset = 1'b1;
    rr = 0;
    exp_cnt = 0;
    elect(4'b1111, org);
    chk("post_rst_origin", origin_vec, 4'b0001);
    ring = '{4'b0010, 4'b0001};
    walk(ring, org, m);
    report(org, m, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
